icache_blocked: RTL and testbench

Parametrised direct-mapped instruction cache with multi-word blocks, a sequential refill state machine and a synchronous flush. It sits between the datapath instruction-fetch port and the memory controller's per-CPU instruction channel. It replaces the single-word direct-mapped icache in any configuration where block size or set count must scale. A miss fetches the whole block, one word per memory grant, before the line becomes valid.

---
 rtl/icache_blocked.sv | 114 +++++++++++
 tb/tb_icache_blocked.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/icache_blocked.sv
// Direct-mapped instruction cache with multi-word blocks; a miss refills the whole
// block from word 0, one word per memory grant, before the line is marked valid.
module icache_blocked #(
   parameter int unsigned SETS  = 16,
   parameter int unsigned WORDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        flush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int unsigned WB  = $clog2(WORDS);
   localparam int unsigned IB  = $clog2(SETS);
   localparam int unsigned TW  = 30 - WB - IB;
   localparam int unsigned WBW = (WB == 0) ? 1 : WB;

   typedef enum logic {IDLE, FILL} state_t;

   state_t            state_q, state_d;
   logic [SETS-1:0]   valid_q;
   logic [TW-1:0]     tag_q  [SETS];
   logic [31:0]       data_q [SETS][WORDS];
   logic [31:0]       base_q, base_d;
   logic [WBW-1:0]    w_q, w_d;

   logic [WBW-1:0]    req_off;
   logic [IB-1:0]     req_idx, fill_idx;
   logic [TW-1:0]     req_tag, fill_tag;
   logic              grant, last, start, done;

   // Shift-and-mask keeps the offset decode legal when WORDS=1 (zero offset bits).
   assign req_off  = WBW'((imemaddr >> 2) & 32'(WORDS - 1));
   assign req_idx  = imemaddr[WB+IB+1:WB+2];
   assign req_tag  = imemaddr[31:WB+IB+2];
   assign fill_idx = base_q[WB+IB+1:WB+2];
   assign fill_tag = base_q[31:WB+IB+2];

   assign ihit     = (state_q == IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign imemload = data_q[req_idx][req_off];

   assign grant = (state_q == FILL) && !iwait;
   assign last  = (w_q == WBW'(WORDS - 1));

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      w_d     = w_q;
      iREN    = 1'b0;
      iaddr   = '0;
      start   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (imemREN && !ihit && !flush) begin
               state_d = FILL;
               base_d  = {imemaddr[31:WB+2], {(WB+2){1'b0}}};
               w_d     = '0;
               start   = 1'b1;
            end
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = base_q + (32'(w_q) << 2);
            if (grant)
               w_d = w_q + 1'b1;
            // A flush abandons the refill even when the final word lands this cycle.
            if (flush)
               state_d = IDLE;
            else if (grant && last) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         valid_q <= '0;
         base_q  <= '0;
         w_q     <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            tag_q[s] <= '0;
            for (int unsigned k = 0; k < WORDS; k++)
               data_q[s][k] <= '0;
         end
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         w_q     <= w_d;
         if (flush)
            valid_q <= '0;
         else if (start)
            valid_q[req_idx] <= 1'b0;
         else if (done)
            valid_q[fill_idx] <= 1'b1;
         if (grant)
            data_q[fill_idx][w_q] <= iload;
         if (done)
            tag_q[fill_idx] <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_blocked.sv
// Directed bench for icache_blocked: default geometry plus SETS=4/WORDS=1 and
// SETS=64/WORDS=8 instances sharing one stimulus bus.
`timescale 1ns/1ps
module tb_icache_blocked;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN, flush, iwait;
   logic [31:0] imemaddr, iload;

   logic [2:0]       ihit_v, iren_v;
   logic [2:0][31:0] load_v, iaddr_v;

   int unsigned total  = 0;
   int unsigned passed = 0;

   always #5 CLK = ~CLK;

   icache_blocked #(.SETS(16), .WORDS(2)) u0 (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
      .ihit(ihit_v[0]), .imemload(load_v[0]), .iREN(iren_v[0]), .iaddr(iaddr_v[0]),
      .iwait(iwait), .iload(iload));

   icache_blocked #(.SETS(4), .WORDS(1)) u1 (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
      .ihit(ihit_v[1]), .imemload(load_v[1]), .iREN(iren_v[1]), .iaddr(iaddr_v[1]),
      .iwait(iwait), .iload(iload));

   icache_blocked #(.SETS(64), .WORDS(8)) u2 (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
      .ihit(ihit_v[2]), .imemload(load_v[2]), .iREN(iren_v[2]), .iaddr(iaddr_v[2]),
      .iwait(iwait), .iload(iload));

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h40)      return 32'hAAAA_0000;
      else if (a == 32'h44) return 32'hBBBB_0001;
      else                  return {~a[15:0], a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1; imemREN = 1'b0; flush = 1'b0; iwait = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge CLK);
      imemREN = 1'b0; flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
   endtask

   task automatic hit(input int sel, input logic [31:0] addr, input bit exp_hit);
      @(negedge CLK);
      imemREN = 1'b0; imemaddr = addr;
      #1;
      chk("hit_ihit", 32'(ihit_v[sel]), 32'(exp_hit));
      chk("hit_iren", 32'(iren_v[sel]), 32'd0);
      if (exp_hit) chk("hit_load", load_v[sel], mem(addr & ~32'h3));
   endtask

   // Full miss: cycle 0 miss, then (waits+1) cycles per word, then the post-fill cycle.
   task automatic fill(input int sel, input logic [31:0] addr, input int unsigned n,
                       input int unsigned waits, input bit flush_last);
      logic [31:0] base, a;
      base = addr & ~(32'(4 * n) - 32'd1);
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = addr; iwait = 1'b0; flush = 1'b0;
      #1;
      chk("miss_ihit", 32'(ihit_v[sel]), 32'd0);
      chk("miss_iren", 32'(iren_v[sel]), 32'd0);
      for (int unsigned k = 0; k < n; k++) begin
         for (int unsigned t = 0; t <= waits; t++) begin
            @(negedge CLK);
            a     = base + 32'(4 * k);
            iwait = (t < waits);
            iload = mem(a);
            flush = flush_last && (k == n - 1) && (t == waits);
            #1;
            chk("fill_iren", 32'(iren_v[sel]), 32'd1);
            chk("fill_iaddr", iaddr_v[sel], a);
            chk("fill_ihit", 32'(ihit_v[sel]), 32'd0);
         end
      end
      @(negedge CLK);
      imemREN = 1'b0; iwait = 1'b0; flush = 1'b0;
      #1;
      chk("done_iren", 32'(iren_v[sel]), 32'd0);
      chk("done_ihit", 32'(ihit_v[sel]), flush_last ? 32'd0 : 32'd1);
      if (!flush_last) chk("done_load", load_v[sel], mem(addr & ~32'h3));
   endtask

   initial begin
      RST = 1'b1; imemREN = 1'b0; imemaddr = '0; flush = 1'b0; iwait = 1'b0; iload = '0;
      #2;
      chk("rst_ihit", 32'(ihit_v[0]), 32'd0);
      chk("rst_load", load_v[0], 32'd0);
      chk("rst_iren", 32'(iren_v[0]), 32'd0);
      chk("rst_iaddr", iaddr_v[0], 32'd0);
      chk("rst_iaddr_u2", iaddr_v[2], 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // Cold miss and neighbouring-word hit
      fill(0, 32'h40, 2, 0, 1'b0);
      hit(0, 32'h44, 1'b1);

      // Conflict eviction on index 8
      fill(0, 32'hC0, 2, 0, 1'b0);
      hit(0, 32'hC4, 1'b1);
      fill(0, 32'h40, 2, 0, 1'b0);

      // Three wait cycles before each grant
      fill(0, 32'h100, 2, 3, 1'b0);

      // Flush clears everything; flush on the last grant leaves the line invalid
      pulse_flush();
      hit(0, 32'h100, 1'b0);
      hit(0, 32'h40, 1'b0);
      fill(0, 32'h40, 2, 0, 1'b1);
      fill(0, 32'h40, 2, 0, 1'b0);

      // Asynchronous reset after word 0 of a refill
      pulse_flush();
      @(negedge CLK);
      imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0;
      #1;
      chk("ar_miss", 32'(ihit_v[0]), 32'd0);
      @(negedge CLK);
      iload = mem(32'h40);
      #1;
      chk("ar_w0_iaddr", iaddr_v[0], 32'h40);
      @(negedge CLK);
      iwait = 1'b1;
      #1;
      chk("ar_w1_iaddr", iaddr_v[0], 32'h44);
      chk("ar_w1_iren", 32'(iren_v[0]), 32'd1);
      #2;
      RST = 1'b1;
      #1;
      chk("ar_iren", 32'(iren_v[0]), 32'd0);
      chk("ar_ihit", 32'(ihit_v[0]), 32'd0);
      chk("ar_iaddr", iaddr_v[0], 32'd0);
      @(negedge CLK);
      RST = 1'b0; imemREN = 1'b0; iwait = 1'b0;
      hit(0, 32'h40, 1'b0);
      fill(0, 32'h40, 2, 0, 1'b0);

      // SETS=4, WORDS=1
      do_reset();
      fill(1, 32'h40, 1, 0, 1'b0);
      fill(1, 32'h44, 1, 1, 1'b0);
      hit(1, 32'h40, 1'b1);
      fill(1, 32'h50, 1, 0, 1'b0);
      hit(1, 32'h40, 1'b0);
      hit(1, 32'h44, 1'b1);

      // SETS=64, WORDS=8
      do_reset();
      fill(2, 32'h1234, 8, 0, 1'b0);
      hit(2, 32'h123C, 1'b1);
      hit(2, 32'h1220, 1'b1);
      hit(2, 32'h1254, 1'b0);
      fill(2, 32'h1A34, 8, 1, 1'b0);
      hit(2, 32'h1234, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
